// File: rtl/pattern_detector_if.sv
// Serial-stream and match-event signals shared by the front end, the detector and the consumer.
interface pattern_detector_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic             x;
    logic             x_valid;
    logic             overlap_en;
    logic             load_pat;
    logic [N-1:0]     pat_in;
    logic             clr_count;
    logic             z;
    logic             z_reg;
    logic [CNT_W-1:0] match_count;

    modport master (
        output x, x_valid, overlap_en, load_pat, pat_in, clr_count,
        input  z, z_reg, match_count
    );

    modport slave (
        input  x, x_valid, overlap_en, load_pat, pat_in, clr_count,
        output z, z_reg, match_count
    );
endinterface

// File: rtl/pattern_detector.sv
// Serial N-bit pattern detector with run-time reloadable pattern, selectable overlap,
// same-cycle Mealy flag, registered pulse and saturating hit counter.
module pattern_detector #(
    parameter int           N       = 4,
    parameter logic [N-1:0] PATTERN = 4'b0110,
    parameter int           CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    pattern_detector_if.slave bus
);
    localparam int            FW        = $clog2(N);
    localparam logic [FW-1:0] FILL_FULL = FW'(N - 1);

    logic [N-1:0]     r_pat;
    logic [N-2:0]     r_hist;
    logic [FW-1:0]    r_fill;
    logic             r_z_reg;
    logic [CNT_W-1:0] r_count;

    logic [N-1:0]     w_window;
    logic             w_match;

    assign w_window = {r_hist, bus.x};
    assign w_match  = bus.x_valid & ~bus.load_pat & (r_fill == FILL_FULL) & (w_window == r_pat);

    assign bus.z           = w_match;
    assign bus.z_reg       = r_z_reg;
    assign bus.match_count = r_count;

    // A non-overlap hit empties the history so no bit of the matched window is reused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat  <= PATTERN;
            r_hist <= '0;
            r_fill <= '0;
        end else if (bus.load_pat) begin
            r_pat  <= bus.pat_in;
            r_hist <= '0;
            r_fill <= '0;
        end else if (bus.x_valid) begin
            r_hist <= w_window[N-2:0];
            if (w_match) begin
                r_fill <= bus.overlap_en ? FILL_FULL : '0;
            end else if (r_fill != FILL_FULL) begin
                r_fill <= r_fill + FW'(1);
            end
        end
    end

    // Clear beats a simultaneous hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_z_reg <= 1'b0;
            r_count <= '0;
        end else begin
            r_z_reg <= w_match;
            if (bus.clr_count) begin
                r_count <= '0;
            end else if (w_match && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: doc/pattern_detector.md
# pattern_detector

Parametrised serial bit-pattern detector, the general successor of the fixed 0110 Mealy detector. It compares a serial input stream against an N-bit pattern that can be reloaded at run time, with overlap or non-overlap matching selectable per cycle. Each hit produces a same-cycle Mealy flag, a registered one-cycle pulse and a saturating hit count. It sits between a serial front end and the control logic that consumes match events.

## Interface
- N, 4: pattern length in bits; N >= 2.
- PATTERN, 4'b0110: reset pattern, N bits; the MSB is the first bit received.
- CNT_W, 8: match counter width.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- x  input  1  serial data bit.
- x_valid  input  1  x is sampled on this edge only when x_valid=1.
- overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping.
- load_pat  input  1  load pat_in as the new pattern.
- pat_in  input  N  new pattern; the MSB is matched first.
- clr_count  input  1  synchronous clear of match_count.
- z  output  1  Mealy match flag, combinational.
- z_reg  output  1  registered match pulse.
- match_count  output  CNT_W  saturating count of matches.

## Operation
- State registers:
  - pat[N-1:0]: active pattern.
  - hist[N-2:0]: last N-1 accepted bits, newest in bit 0.
  - fill: number of valid history bits, 0..N-1, saturating at N-1.
- Match term: x_valid & ~load_pat & (fill == N-1) & ({hist, x} == pat).
- z equals the match term combinationally, so it depends on the current x.
- Accepted sample (x_valid=1, load_pat=0):
  - hist shifts left, taking x into bit 0.
  - On a match with overlap_en=1: fill stays at N-1.
  - On a match with overlap_en=0: fill goes to 0, so no bit of the matched window is reused.
  - With no match: fill increments, saturating at N-1.
- x_valid=0: hist and fill hold, z=0.
- load_pat=1:
  - pat <= pat_in, hist <= 0, fill <= 0.
  - Any concurrent sample is discarded and z=0.
  - Load takes priority over x_valid.
- overlap_en is read on the cycle of the match. It may change at any time with no other effect.
- match_count:
  - Increments by 1 on every edge where the match term is 1.
  - Saturates at 2^CNT_W-1.
  - clr_count=1 forces 0. If a match occurs in the same cycle, clear wins and the result is 0, not 1.
- z_reg <= match term on every edge.
- Reset, asynchronous, including mid-stream:
  - pat=PATTERN, hist=0, fill=0, z_reg=0, match_count=0.
  - z is 0 while reset is high.

## Timing
- z: zero latency. High in the same cycle the final pattern bit is presented with x_valid=1, before the sampling edge.
- z_reg and match_count: update on the sampling edge of the final bit, one cycle after z.
- First match possible on the N-th accepted bit after reset, after load_pat, or after a non-overlap match.
- Gaps (x_valid=0) do not break a partial match; only accepted bits count.
- A new pattern is active for the first accepted bit after the load edge.
- Back-to-back matches with overlap_en=1 can occur on consecutive accepted bits, e.g. pattern 1111. z_reg then stays high for consecutive cycles.
- Reset release: the first edge after reset deasserts is a normal sampling edge.

## Test plan
- Default pattern 0110, overlap_en=1, x_valid=1. Stream 0,0,1,1,0,1,1,0,0,1,1,0 -> z high on bits 4, 7 and 11 (0-based); match_count=3.
- Same stream with overlap_en=0 -> z high on bits 4 and 11 only; match_count=2.
- Load pat_in=1111, then six 1s with overlap_en=1 -> 3 matches. Repeat with overlap_en=0 -> 1 match. Asserting load_pat together with x_valid=1 drops that sample: z=0, fill=0.
- Stream 0,1,1,0 with x_valid dropped for 3 cycles between each bit -> single match on the final accepted bit; z_reg high for exactly one cycle after it.
- CNT_W=2 with 5 matches -> match_count saturates at 3. Then clr_count=1 in the same cycle as a match -> match_count=0.
- Assert reset asynchronously after 0,1,1 of 0110 -> all outputs 0 immediately. After release, bit 0 alone gives no match; a full 0,1,1,0 is needed for the next z.
